shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequencer and register file for the 8x8 signed (two's-complement) add/shift multiplier. Holds the X/A/B product registers and the latched multiplicand M, drives the external 9-bit add/subtract stage each iteration, and captures its 9-bit result back into {X,A}. It sits directly upstream and downstream of that adder, and feeds the hex-display/LED output logic.

## Interface
Parameters: none (8-bit operands fixed).
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- Run  in  1  level; start multiply (held-button semantics)
- ClearA_LoadB  in  1  level; clear X/A, load B from Din
- Din  in  8  switch operand: multiplier on ClearA_LoadB, multiplicand on Run
- adder_sum  in  9  result from adder; [8] = sign-extension bit
- adder_a  out  8  = A register
- adder_b  out  8  = M register
- adder_fn  out  1  0 = add, 1 = subtract; 1 only in the ADD state of iteration 7
- Aval  out  8  A register (product high byte)
- Bval  out  8  B register (product low byte)
- X  out  1  sign-extension register
- busy  out  1  high in START/ADD/SHIFT
- done  out  1  high in DONE

## Operation
- States: IDLE, START, ADD, SHIFT, DONE; 3-bit iteration counter cnt (0..7).
- IDLE: Run=1 -> START. Else if ClearA_LoadB=1 -> X<=0, A<=0, B<=Din, stay. Run wins if both high.
- START: X<=0, A<=0, M<=Din, cnt<=0, -> ADD. B retained, so chained multiplies use the previous low byte.
- ADD: if B[0]=1, {X,A}<=adder_sum; else hold. Subtract (adder_fn=1) only when cnt=7, otherwise add. -> SHIFT.
- SHIFT: arithmetic right shift of {X,A,B}: X holds, A<={X,A[7:1]}, B<={A[0],B[7:1]}. If cnt=7 -> DONE, else cnt<=cnt+1, -> ADD.
- DONE: product = {A,B} (16-bit signed), X = product sign. Stay while Run=1; Run=0 -> IDLE. ClearA_LoadB ignored.
- Width rules: adder operates on 9 bits (A and M sign-extended by the adder). The result is truncated to 16 bits {A,B}. Two's-complement wrap is exact for all 8x8 pairs.
- Din changes after START have no effect; M is latched.

## Timing
- Reset values: A=0, B=0, M=0, X=0, cnt=0, state=IDLE, busy=0, done=0, adder_fn=0.
- Run sampled high in IDLE at edge 0: START executes at edge 1, ADD_i at edge 2+2i, SHIFT_i at edge 3+2i.
- Fixed latency: done=1 from after edge 17, regardless of operand values; busy=1 from after edge 0 through edge 17.
- Run held high indefinitely yields exactly one multiplication. A new multiply needs Run=0 for at least 1 cycle (DONE->IDLE), then Run=1.
- Run deasserted mid-operation does not abort.
- Reset mid-operation: at the next edge all registers return to reset values and state=IDLE. Partial results are discarded.
- ClearA_LoadB takes effect at the next edge, in IDLE only.
- adder_fn and adder_a/adder_b are combinational from state/registers. adder_sum is sampled only at the ADD edge.

## Test plan
- Reset; Din=0x03, ClearA_LoadB pulse; Din=0x05, Run -> after edge 17: done=1, Aval=0x00, Bval=0x0F, X=0.
- B=0xFD (-3), M=0x07 -> {A,B}=0xFFEB (-21), X=1; adder_fn=1 observed only at edge 16.
- B=0x80, M=0x80 -> {A,B}=0x4000, X=0. Also B=0x7F, M=0x80 -> 0xC080, X=1.
- Chained: after the first case, drop Run for 1 cycle, Din=0x02, Run -> {A,B}=0x001E, with no ClearA_LoadB between runs.
- Reset asserted at edge 9 of a multiply -> next edge: all outputs 0, IDLE. With Run=0, no activity follows.
- Run held 40 cycles -> single done assertion, registers stable after edge 17. ClearA_LoadB pulsed in DONE -> B unchanged. Both Run and ClearA_LoadB high in IDLE -> multiply starts, B not reloaded.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequencer and X/A/B/M register file for an 8x8 signed add/shift multiplier.
// Drives an external 9-bit add/subtract stage and captures its result into {X,A}.
module shift_add_multiplier (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] Din,
  input  logic [8:0] adder_sum,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  output logic       adder_fn,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic       x_q, x_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] m_q, m_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      x_q     <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      m_q     <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (Run) begin
          state_d = StStart;
        end else if (ClearA_LoadB) begin
          x_d = 1'b0;
          a_d = 8'h00;
          b_d = Din;
        end
      end
      StStart: begin
        // B is deliberately kept so back-to-back runs reuse the previous low byte
        x_d     = 1'b0;
        a_d     = 8'h00;
        m_d     = Din;
        cnt_d   = 3'd0;
        state_d = StAdd;
      end
      StAdd: begin
        if (b_q[0]) begin
          {x_d, a_d} = adder_sum;
        end
        state_d = StShift;
      end
      StShift: begin
        a_d = {x_q, a_q[7:1]};
        b_d = {a_q[0], b_q[7:1]};
        if (cnt_q == 3'd7) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = StAdd;
        end
      end
      StDone: begin
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The multiplier's sign bit carries negative weight, so the last partial product subtracts
  assign adder_fn = (state_q == StAdd) && (cnt_q == 3'd7);
  assign adder_a  = a_q;
  assign adder_b  = m_q;
  assign Aval     = a_q;
  assign Bval     = b_q;
  assign X        = x_q;
  assign busy     = (state_q == StStart) || (state_q == StAdd) || (state_q == StShift);
  assign done     = (state_q == StDone);

endmodule
